alu_op_issue: RTL and testbench

Decode-to-execute issue stage that produces the `Operation`, `SrcA` and `SrcB` inputs of the combinational ALU. It sits between register-file read and the ALU. Each cycle it:
- decodes one RV32I instruction into the ALU's 4-bit operation code,
- selects register or immediate operands,
- registers the result into a single-entry ID/EX pipeline slot with valid/ready flow control and flush.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_op_decode.sv | 123 ++++++++++++
 rtl/alu_op_issue.sv | 76 +++++++
 tb/tb_alu_op_issue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALU operation codes and RV32I fields.
package alu_pkg;

    // 4-bit operation codes understood by the combinational ALU.
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SRA = 4'b0110,
        ALU_SLL = 4'b0111,
        ALU_SLT = 4'b1000,
        ALU_BEQ = 4'b1001,
        ALU_BNE = 4'b1010,
        ALU_BGE = 4'b1011,
        ALU_JAL = 4'b1111
    } alu_op_e;

    // RV32I major opcodes handled by this stage.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // funct7 values: base encoding and the SUB/SRA alternate.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into ALU operation, operands and immediate.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [31:0]               instr,
    input  logic [DATA_WIDTH-1:0]     rd1,
    input  logic [DATA_WIDTH-1:0]     rd2,
    output logic [OPCODE_LENGTH-1:0]  operation,
    output logic [DATA_WIDTH-1:0]     srca,
    output logic [DATA_WIDTH-1:0]     srcb,
    output logic [DATA_WIDTH-1:0]     imm,
    output logic                      illegal
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [DATA_WIDTH-1:0] imm_j;
    alu_op_e               op;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Every immediate format sign-extends from instr[31].
    assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    assign srca      = rd1;
    assign operation = OPCODE_LENGTH'(op);

    // Decode opcode/funct fields; unsupported encodings fall back to AND, SrcB 0, illegal.
    always_comb begin
        op      = ALU_AND;
        srcb    = '0;
        imm     = '0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                srcb = rd2;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE)     op = ALU_ADD;
                        else if (funct7 == F7_ALT) op = ALU_SUB;
                        else                       illegal = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     op = ALU_SRL;
                        else if (funct7 == F7_ALT) op = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    3'b111:  if (funct7 == F7_BASE) op = ALU_AND; else illegal = 1'b1;
                    3'b110:  if (funct7 == F7_BASE) op = ALU_OR;  else illegal = 1'b1;
                    3'b100:  if (funct7 == F7_BASE) op = ALU_XOR; else illegal = 1'b1;
                    3'b001:  if (funct7 == F7_BASE) op = ALU_SLL; else illegal = 1'b1;
                    3'b010:  if (funct7 == F7_BASE) op = ALU_SLT; else illegal = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            OP_I: begin
                srcb = imm_i;
                imm  = imm_i;
                case (funct3)
                    3'b000: op = ALU_ADD;
                    3'b010: op = ALU_SLT;
                    3'b111: op = ALU_AND;
                    3'b110: op = ALU_OR;
                    3'b100: op = ALU_XOR;
                    3'b001:  if (funct7 == F7_BASE) op = ALU_SLL; else illegal = 1'b1;
                    3'b101: begin
                        if (funct7 == F7_BASE)     op = ALU_SRL;
                        else if (funct7 == F7_ALT) op = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                op   = ALU_ADD;
                srcb = imm_i;
                imm  = imm_i;
            end
            OP_STORE: begin
                op   = ALU_ADD;
                srcb = imm_s;
                imm  = imm_s;
            end
            OP_BRANCH: begin
                srcb = rd2;
                imm  = imm_b;
                case (funct3)
                    3'b000:  op = ALU_BEQ;
                    3'b001:  op = ALU_BNE;
                    3'b100:  op = ALU_SLT;
                    3'b101:  op = ALU_BGE;
                    default: illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                op  = ALU_JAL;
                imm = imm_j;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal entries always present a clean, known payload.
        if (illegal) begin
            op   = ALU_AND;
            srcb = '0;
            imm  = '0;
        end
    end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX issue stage: decode plus a single-entry registered slot with flush.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready = !out_valid || out_ready (never depends on in_valid). While
// out_valid && !out_ready every out_* is held bit-stable. flush wins over all.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [DATA_WIDTH-1:0]     in_rd1,
    input  logic [DATA_WIDTH-1:0]     in_rd2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPCODE_LENGTH-1:0]  out_operation,
    output logic [DATA_WIDTH-1:0]     out_srca,
    output logic [DATA_WIDTH-1:0]     out_srcb,
    output logic [DATA_WIDTH-1:0]     out_imm,
    output logic                      out_illegal
);

    logic [OPCODE_LENGTH-1:0] dec_operation;
    logic [DATA_WIDTH-1:0]    dec_srca;
    logic [DATA_WIDTH-1:0]    dec_srcb;
    logic [DATA_WIDTH-1:0]    dec_imm;
    logic                     dec_illegal;
    logic                     capture;

    alu_op_decode #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_decode (
        .instr     (in_instr),
        .rd1       (in_rd1),
        .rd2       (in_rd2),
        .operation (dec_operation),
        .srca      (dec_srca),
        .srcb      (dec_srcb),
        .imm       (dec_imm),
        .illegal   (dec_illegal)
    );

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Pipeline slot: flush empties it, otherwise refill or drain whenever ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_operation <= '0;
            out_srca      <= '0;
            out_srcb      <= '0;
            out_imm       <= '0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (capture) begin
                out_operation <= dec_operation;
                out_srca      <= dec_srca;
                out_srcb      <= dec_srcb;
                out_imm       <= dec_imm;
                out_illegal   <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: decode vector table through a scoreboard, plus
// hand-written stall, flush and reset-mid-stall sequences.
module tb_alu_op_issue;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [31:0] imm;
        logic        ill;
    } exp_t;
    localparam int W = $bits(exp_t);

    typedef struct {
        logic [31:0] instr;
        logic        srcb_rd2;   // expected SrcB is the rs2 data
        logic [3:0]  op;
        logic [31:0] srcb;       // expected SrcB when not taken from rs2
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    localparam int NV = 24;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rd1;
    logic [31:0] in_rd2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_operation;
    logic [31:0] out_srca;
    logic [31:0] out_srcb;
    logic [31:0] out_imm;
    logic        out_illegal;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    vec_t         vecs[NV];

    alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_rd1        (in_rd1),
        .in_rd2        (in_rd2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_operation (out_operation),
        .out_srca      (out_srca),
        .out_srcb      (out_srcb),
        .out_imm       (out_imm),
        .out_illegal   (out_illegal)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every consumed entry must match the oldest expected record.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry: got op 0x%0h srca 0x%08h with empty queue",
                         out_operation, out_srca);
            end else begin
                exp_t e;
                e = exp_t'(exp_q.pop_front());
                check("sb_op",   {28'd0, out_operation}, {28'd0, e.op});
                check("sb_srca", out_srca, e.srca);
                check("sb_srcb", out_srcb, e.srcb);
                check("sb_imm",  out_imm,  e.imm);
                check("sb_ill",  {31'd0, out_illegal}, {31'd0, e.ill});
            end
        end
    end

    // Offer one instruction; push its expectation when it is accepted.
    task automatic send(input vec_t v, input logic [31:0] rd1, input logic [31:0] rd2);
        exp_t e;
        bit   done;
        done     = 0;
        in_valid = 1'b1;
        in_instr = v.instr;
        in_rd1   = rd1;
        in_rd2   = rd2;
        e.op   = v.op;
        e.srca = rd1;
        e.srcb = v.srcb_rd2 ? rd2 : v.srcb;
        e.imm  = v.imm;
        e.ill  = v.ill;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                exp_q.push_back(W'(e));
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr 0x%08h never accepted", v.instr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        //          instr         rd2  op     srcb          imm           ill
        vecs[0]  = '{32'h002081B3, 1, 4'h2, 32'h0,        32'h0,        0}; // add
        vecs[1]  = '{32'h402081B3, 1, 4'h3, 32'h0,        32'h0,        0}; // sub
        vecs[2]  = '{32'hFFF00093, 0, 4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0}; // addi -1
        vecs[3]  = '{32'h00208463, 1, 4'h9, 32'h0,        32'h00000008, 0}; // beq +8
        vecs[4]  = '{32'h0020C1B3, 1, 4'h4, 32'h0,        32'h0,        0}; // xor
        vecs[5]  = '{32'h0020D1B3, 1, 4'h5, 32'h0,        32'h0,        0}; // srl
        vecs[6]  = '{32'h4020D1B3, 1, 4'h6, 32'h0,        32'h0,        0}; // sra
        vecs[7]  = '{32'h002091B3, 1, 4'h7, 32'h0,        32'h0,        0}; // sll
        vecs[8]  = '{32'h0020A1B3, 1, 4'h8, 32'h0,        32'h0,        0}; // slt
        vecs[9]  = '{32'h0020F1B3, 1, 4'h0, 32'h0,        32'h0,        0}; // and
        vecs[10] = '{32'h0020E1B3, 1, 4'h1, 32'h0,        32'h0,        0}; // or
        vecs[11] = '{32'h0220F1B3, 0, 4'h0, 32'h0,        32'h0,        1}; // R bad funct7
        vecs[12] = '{32'h0020B1B3, 0, 4'h0, 32'h0,        32'h0,        1}; // sltu unsupported
        vecs[13] = '{32'h4030D093, 0, 4'h6, 32'h00000403, 32'h00000403, 0}; // srai 3
        vecs[14] = '{32'h40309093, 0, 4'h0, 32'h0,        32'h0,        1}; // slli bad funct7
        vecs[15] = '{32'h0F00F093, 0, 4'h0, 32'h000000F0, 32'h000000F0, 0}; // andi 0xF0
        vecs[16] = '{32'hFFC12083, 0, 4'h2, 32'hFFFFFFFC, 32'hFFFFFFFC, 0}; // lw -4
        vecs[17] = '{32'h0020A423, 0, 4'h2, 32'h00000008, 32'h00000008, 0}; // sw +8
        vecs[18] = '{32'hFE209EE3, 1, 4'hA, 32'h0,        32'hFFFFFFFC, 0}; // bne -4
        vecs[19] = '{32'h0020C463, 1, 4'h8, 32'h0,        32'h00000008, 0}; // blt
        vecs[20] = '{32'h0020D463, 1, 4'hB, 32'h0,        32'h00000008, 0}; // bge
        vecs[21] = '{32'h0020A463, 0, 4'h0, 32'h0,        32'h0,        1}; // branch f3=010
        vecs[22] = '{32'h0080006F, 0, 4'hF, 32'h0,        32'h00000008, 0}; // jal +8
        vecs[23] = '{32'hFFFFF06F, 0, 4'hF, 32'h0,        32'hFFFFFFFE, 0}; // jal -2

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_rd1    = 32'h0;
        in_rd2    = 32'h0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_op",        {28'd0, out_operation}, 32'd0);
        check("rst_srca",      out_srca, 32'd0);
        check("rst_srcb",      out_srcb, 32'd0);
        check("rst_imm",       out_imm,  32'd0);
        check("rst_ill",       {31'd0, out_illegal}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed first transaction: add with rd1=5, rd2=7
        send(vecs[0], 32'd5, 32'd7);
        in_valid = 1'b0;
        @(negedge clk);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back sub then addi: one per cycle, no bubble
        send(vecs[1], 32'd20, 32'd3);
        send(vecs[2], 32'd0, 32'd99);
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid2", {31'd0, out_valid}, 32'd1);
        check("b2b_op2",    {28'd0, out_operation}, 32'h2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Directed beq with rd2=9
        send(vecs[3], 32'd1, 32'd9);
        idle(2);

        // Whole table back-to-back with random register data
        for (int i = 0; i < NV; i++) begin
            send(vecs[i], $urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 0));
        end
        idle(3);
        check("table_drained", exp_q.size(), 32'd0);

        // Stall: hold add for 3 cycles while xor is offered
        out_ready = 1'b0;
        send(vecs[0], 32'd5, 32'd7);
        in_instr = vecs[4].instr;
        in_rd1   = 32'd3;
        in_rd2   = 32'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid",    {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready},  32'd0);
            check("stall_op",       {28'd0, out_operation}, 32'h2);
            check("stall_srca",     out_srca, 32'd5);
            check("stall_srcb",     out_srcb, 32'd7);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(W'(exp_t'{4'h4, 32'd3, 32'd4, 32'd0, 1'b0}));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("release_xor_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        idle(2);

        // Flush with held entry and a same-cycle input
        out_ready = 1'b0;
        send(vecs[0], 32'd11, 32'd12);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = vecs[1].instr;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        idle(3);
        check("flush_nothing_left", exp_q.size(), 32'd0);

        // Illegal opcode, then reset pulsed mid-stall
        out_ready = 1'b0;
        send('{32'h0000007B, 0, 4'h0, 32'h0, 32'h0, 1'b1}, 32'd1, 32'd2);
        in_valid = 1'b0;
        @(negedge clk);
        check("ill_valid", {31'd0, out_valid}, 32'd1);
        check("ill_flag",  {31'd0, out_illegal}, 32'd1);
        check("ill_op",    {28'd0, out_operation}, 32'h0);
        check("ill_srcb",  out_srcb, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid",    {31'd0, out_valid}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready},  32'd1);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        idle(3);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
